rr_grant_sel: RTL and testbench
===============================

// Module: rr_grant_sel
// PURPOSE
//  Round-robin arbiter among 4 requesters; output is a registered 2-bit grant index plus valid.
//  Sits directly upstream of the 2-to-4 one-hot decoder stage: gnt_idx drives the decoder's
//  2-bit select, and gnt_vld qualifies the decoder output.
//  Holds a grant until the owner releases it, drops its request, or the hold timeout expires.
// PARAMETERS
//  MAX_HOLD  15  max consecutive cycles gnt_vld may stay high for one grant; 0 = no timeout
//  CNT_W     4   hold counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk      in   1  single clock, rising edge
//  rst      in   1  asynchronous reset, active-high
//  en       in   1  1 = new grants allowed; 0 blocks new grants only, not an active grant
//  req      in   4  request vector, bit n = requester n
//  release  in   1  owner of the current grant is finished; sampled only in GRANT
//  gnt_idx  out  2  index of granted requester, registered
//  gnt_vld  out  1  gnt_idx is a valid grant, registered
//  timeout  out  1  one-cycle pulse: grant was revoked by MAX_HOLD expiry
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, ptr=0, hold_cnt=0, gnt_idx=2'b00, gnt_vld=0, timeout=0.
//  States:
//   - IDLE: if en && |req, pick the first set req bit searching ptr, ptr+1, ... mod 4.
//     At the next edge: gnt_idx=pick, gnt_vld=1, hold_cnt=0, go to GRANT.
//     Otherwise remain in IDLE, gnt_vld=0.
//   - GRANT: hold_cnt increments each cycle. Exit to IDLE at the edge when any of:
//     (a) release=1;
//     (b) req[gnt_idx]=0 (requester dropped);
//     (c) MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1.
//     On exit: gnt_vld=0, ptr=gnt_idx+1 (2-bit wrap, 3->0), hold_cnt=0.
//     timeout=1 for exactly one cycle only when (c) is the sole cause.
//  Timing:
//   - Latency: req seen in an IDLE cycle -> gnt_vld=1 in the following cycle.
//   - Back-to-back grants are separated by exactly one cycle with gnt_vld=0 (the IDLE arbitration cycle).
//   - A timed-out grant stays high exactly MAX_HOLD cycles; timeout is coincident with the first gnt_vld=0 cycle.
//  Boundary and priority rules:
//   - gnt_idx holds its last value while gnt_vld=0; the downstream stage gates on gnt_vld.
//   - Changes on non-granted req bits during GRANT are ignored.
//   - release while in IDLE is ignored.
//   - Simultaneous release and drop and/or timeout: a single exit, and timeout stays 0.
//   - en falling during GRANT has no effect. en=0 in IDLE keeps gnt_vld=0 and does not move ptr.
//   - Single requester: may be re-granted immediately after its own exit (gap of 1 cycle).
//   - rst asserted mid-grant: all outputs clear immediately; ptr returns to 0.
//   - The hold counter saturates and never wraps. It cannot reach 2**CNT_W-1 when CNT_W
//     is legal; MAX_HOLD=0 with a long grant holds it at its maximum.
// STRUCTURE
//  Shared package arb_pkg:
//   - N_REQ=4, IDX_W=2
//   - state typedef/localparams ST_IDLE=1'b0, ST_GRANT=1'b1
//  Sub-module rr_pick4 (combinational):
//   - inputs req[3:0], ptr[1:0]; outputs pick[1:0], any
//   - rotate-then-priority-encode
//  Top level holds the FSM, ptr, hold_cnt and output registers only. All registers share one
//  always block style with async rst in the sensitivity list.
// TESTING
//  1. rst=1 for 3 cycles with req=4'b1111 -> gnt_vld=0, gnt_idx=0, timeout=0 throughout.
//  2. ptr=0, req=4'b1010 -> gnt_idx=1, gnt_vld=1 one cycle later; release=1 -> 1 cycle
//     gnt_vld=0, then gnt_idx=3.
//  3. req=4'b1111 held, release pulsed 2 cycles after each grant -> grant order 0,1,2,3,0,
//     one dead cycle between each.
//  4. MAX_HOLD=4, req=4'b0100 held, no release -> gnt_vld high exactly 4 cycles, timeout=1
//     next cycle, then re-grant idx 2.
//  5. Granted idx 2, req[2] drops together with release=1 -> gnt_vld=0 next cycle,
//     timeout=0, next grant search starts at 3.
//  6. rst pulsed mid-grant (between clock edges) -> gnt_vld falls before next edge; after
//     rst, req=4'b1000 -> gnt_idx=3.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the round-robin grant selector.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } st_e;

  // Next requester index after idx, wrapping 3 -> 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_pick_c,
  output logic             o_any_c
);

  // Rotate by ptr then priority-encode; scanning downwards lets the offset closest to ptr win.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    v_idx    = '0;
    o_pick_c = '0;
    o_any_c  = 1'b0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      v_idx = i_ptr + IDX_W'(i);
      if (i_req[v_idx]) begin
        o_pick_c = v_idx;
        o_any_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_sel.sv
// Round-robin arbiter over 4 requesters with registered grant index/valid and hold timeout.
module rr_grant_sel
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_vld,
  output logic             o_timeout
);

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_SAT  = {CNT_W{1'b1}};

  st_e              r_state,    w_state_nxt;
  logic [IDX_W-1:0] r_ptr,      w_ptr_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [IDX_W-1:0] r_gnt_idx,  w_gnt_idx_nxt;
  logic             r_gnt_vld,  w_gnt_vld_nxt;
  logic             r_timeout,  w_timeout_nxt;

  logic [IDX_W-1:0] w_pick;
  logic             w_any;
  logic             w_exit_rel;
  logic             w_exit_drop;
  logic             w_exit_to;

  rr_pick4 u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_pick_c (w_pick),
    .o_any_c  (w_any)
  );

  // Exit causes while a grant is held.
  assign w_exit_rel  = i_release;
  assign w_exit_drop = !i_req[r_gnt_idx];
  assign w_exit_to   = HOLD_EN && (r_hold_cnt == HOLD_LAST);

  // Next-state and next-output decode; gnt_idx keeps its value whenever no new grant is made.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gnt_idx_nxt = r_gnt_idx;
    w_gnt_vld_nxt = 1'b0;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_en && w_any) begin
          w_state_nxt   = ST_GRANT;
          w_gnt_idx_nxt = w_pick;
          w_gnt_vld_nxt = 1'b1;
          w_hold_nxt    = '0;
        end
      end
      ST_GRANT: begin
        if (w_exit_rel || w_exit_drop || w_exit_to) begin
          w_state_nxt   = ST_IDLE;
          w_ptr_nxt     = next_idx(r_gnt_idx);
          w_hold_nxt    = '0;
          w_timeout_nxt = w_exit_to && !w_exit_rel && !w_exit_drop;
        end else begin
          w_gnt_vld_nxt = 1'b1;
          if (r_hold_cnt != HOLD_SAT) begin
            w_hold_nxt = r_hold_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pointer, hold counter and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt_idx  <= '0;
      r_gnt_vld  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_gnt_vld  <= w_gnt_vld_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign o_gnt_idx = r_gnt_idx;
  assign o_gnt_vld = r_gnt_vld;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_grant_sel.sv
// Self-checking bench for rr_grant_sel: reference model feeds a scoreboard queue.
module tb_rr_grant_sel;

  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned CNT_W    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0;
  logic       rel = 1'b0;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit       m_grant = 1'b0;
  int       m_ptr   = 0;
  int       m_cnt   = 0;
  int       m_idx   = 0;
  bit       m_vld   = 1'b0;
  bit       m_to    = 1'b0;

  logic [3:0] exp_q[$];
  int         order_q[$];

  rr_grant_sel #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_req     (req),
    .i_release (rel),
    .o_gnt_idx (gnt_idx),
    .o_gnt_vld (gnt_vld),
    .o_timeout (tmo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant = 1'b0; m_ptr = 0; m_cnt = 0; m_idx = 0; m_vld = 1'b0; m_to = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs present before that edge.
  task automatic model_step(input bit e, input logic [3:0] r, input bit rl);
    bit drop, hit;
    int c;
    m_to = 1'b0;
    if (!m_grant) begin
      m_vld = 1'b0;
      if (e) begin
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
          c = (m_ptr + k) % 4;
          if (!hit && r[c]) begin
            hit = 1'b1; m_idx = c; m_vld = 1'b1; m_cnt = 0; m_grant = 1'b1;
          end
        end
      end
    end else begin
      drop = !r[m_idx];
      hit  = (MAX_HOLD != 0) && (m_cnt == int'(MAX_HOLD) - 1);
      if (rl || drop || hit) begin
        m_grant = 1'b0; m_vld = 1'b0; m_ptr = (m_idx + 1) % 4; m_cnt = 0;
        m_to = hit && !rl && !drop;
      end else begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
  endtask

  // Drive one cycle of inputs, push the model's expectation, compare after the edge.
  task automatic step(input bit e, input logic [3:0] r, input bit rl, input string tag);
    logic [3:0] exp_v;
    en = e; req = r; rel = rl;
    model_step(e, r, rl);
    exp_q.push_back({2'(m_idx), m_vld, m_to});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    check_eq(tag, 32'({gnt_idx, gnt_vld, tmo}), 32'(exp_v));
  endtask

  initial begin
    int hi;
    bit fell;

    // Reset held with all requests active.
    en = 1'b1; req = 4'b1111; rel = 1'b0; rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rst_out", 32'({gnt_idx, gnt_vld, tmo}), 32'h0);
    end
    rst = 1'b0;

    // Basic grant from ptr 0, then release hands over to idx 3.
    step(1'b1, 4'b1010, 1'b0, "t2_grant");
    check_eq("t2_idx1", 32'(gnt_idx), 32'd1);
    check_eq("t2_vld1", 32'(gnt_vld), 32'd1);
    step(1'b1, 4'b1010, 1'b1, "t2_rel");
    check_eq("t2_gap", 32'(gnt_vld), 32'd0);
    step(1'b1, 4'b1010, 1'b0, "t2_regrant");
    check_eq("t2_idx3", 32'(gnt_idx), 32'd3);
    step(1'b1, 4'b1010, 1'b1, "t2_rel2");

    // All requesting, release two cycles after each grant: order 0,1,2,3,0.
    for (int g = 0; g < 5; g++) begin
      step(1'b1, 4'b1111, 1'b0, "t3_arb");
      order_q.push_back(int'(gnt_idx));
      step(1'b1, 4'b1111, 1'b0, "t3_hold");
      step(1'b1, 4'b1111, 1'b1, "t3_rel");
      check_eq("t3_dead", 32'(gnt_vld), 32'd0);
    end
    begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      for (int g = 0; g < 5; g++) check_eq("t3_order", 32'(order_q[g]), 32'(exp_order[g]));
    end

    // Hold timeout with a single persistent requester.
    hi = 0; fell = 1'b0;
    for (int c = 0; c < 12 && !fell; c++) begin
      step(1'b1, 4'b0100, 1'b0, "t4_cyc");
      if (gnt_vld) hi++;
      else if (hi != 0) begin
        fell = 1'b1;
        check_eq("t4_tmo", 32'(tmo), 32'd1);
      end
    end
    check_eq("t4_fell", 32'(fell), 32'd1);
    check_eq("t4_hicnt", 32'(hi), 32'(MAX_HOLD));
    step(1'b1, 4'b0100, 1'b0, "t4_regrant");
    check_eq("t4_idx2", 32'({gnt_idx, gnt_vld}), 32'({2'd2, 1'b1}));

    // Drop and release together on idx 2: no timeout, next search from 3.
    step(1'b1, 4'b1001, 1'b1, "t5_exit");
    check_eq("t5_vld", 32'({gnt_vld, tmo}), 32'd0);
    step(1'b1, 4'b1001, 1'b0, "t5_next");
    check_eq("t5_idx3", 32'(gnt_idx), 32'd3);
    step(1'b1, 4'b1001, 1'b1, "t5_rel");

    // en low in IDLE blocks grants; en low in GRANT does not revoke.
    step(1'b0, 4'b1111, 1'b0, "en_block");
    check_eq("en_block_vld", 32'(gnt_vld), 32'd0);
    step(1'b1, 4'b0010, 1'b0, "en_grant");
    step(1'b0, 4'b0011, 1'b0, "en_hold");
    check_eq("en_hold_vld", 32'(gnt_vld), 32'd1);

    // Async reset mid-grant clears outputs before the next edge.
    #3 rst = 1'b1;
    #1;
    check_eq("t6_async", 32'({gnt_idx, gnt_vld, tmo}), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 4'b1000, 1'b0, "t6_post");
    check_eq("t6_idx3", 32'({gnt_idx, gnt_vld}), 32'({2'd3, 1'b1}));
    step(1'b1, 4'b1000, 1'b1, "t6_rel");

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
